// File: rtl/mpsoc_msi_wb_ram_slave.sv
// Wishbone B3 RAM slave with classic and registered-feedback burst support.
// Accesses inside the decoded window are served from an on-chip word array.
// Accesses outside the window get a single-cycle error termination.
// Bursts may be linear or wrap-4/8/16. Data is read one cycle ahead, so every
// acked beat already has its word waiting on wb_dat_o.
module mpsoc_msi_wb_ram_slave #(
    parameter int          DW       = 32,
    parameter int          AW       = 10,
    parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [31:0]     wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o
);

    localparam int SW    = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLASSIC = 2'd1,
        ST_BURST   = 2'd2,
        ST_ERR     = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [AW-1:0]   adr_r;
    logic [AW-1:0]   adr_s;
    logic [AW-1:0]   rd_adr_s;
    logic [DW-1:0]   dat_r;
    logic [DW-1:0]   mem_r [0:DEPTH-1];
    logic            req_s;
    logic            hit_s;
    logic [AW-1:0]   word_s;
    logic            ack_s;
    logic            err_s;
    logic            wr_s;
    logic            unused_s;

    // Next beat address: linear bursts roll over the whole array, wrapping
    // bursts only count in the low 2/3/4 bits and keep the upper bits.
    function automatic logic [AW-1:0] next_beat(input logic [AW-1:0] a,
                                                input logic [1:0]    bte);
        logic [AW-1:0] mask;
        logic [AW-1:0] inc;
        inc = a + {{(AW-1){1'b0}}, 1'b1};
        case (bte)
            2'b01:   mask = AW'(4'h3);
            2'b10:   mask = AW'(4'h7);
            2'b11:   mask = AW'(4'hf);
            default: mask = {AW{1'b1}};
        endcase
        return (a & ~mask) | (inc & mask);
    endfunction

    assign req_s    = wb_cyc_i & wb_stb_i;
    assign hit_s    = (wb_adr_i[31:AW+2] == BASE_ADR[31:AW+2]);
    assign word_s   = wb_adr_i[AW+1:2];
    assign unused_s = ^wb_adr_i[1:0];

    // Next-state, beat-address and termination decode for the access FSM.
    always_comb begin
        state_s  = state_r;
        adr_s    = adr_r;
        rd_adr_s = adr_r;
        ack_s    = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                rd_adr_s = word_s;
                if (req_s) begin
                    adr_s = word_s;
                    if (!hit_s) begin
                        state_s = ST_ERR;
                    end else if (wb_cti_i == 3'b010) begin
                        state_s = ST_BURST;
                    end else begin
                        state_s = ST_CLASSIC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLASSIC: begin
                ack_s   = req_s;
                state_s = ST_IDLE;
            end
            ST_BURST: begin
                // A dropped strobe or a switch to classic cancels the
                // speculative beat before it is acknowledged.
                if (!req_s || (wb_cti_i == 3'b000)) begin
                    state_s = ST_IDLE;
                end else begin
                    ack_s    = 1'b1;
                    adr_s    = next_beat(adr_r, wb_bte_i);
                    rd_adr_s = adr_s;
                    if (wb_cti_i == 3'b111) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_BURST;
                    end
                end
            end
            ST_ERR: begin
                err_s   = req_s;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign wr_s = ack_s & wb_we_i;

    // FSM state and beat address registers.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_r <= ST_IDLE;
            adr_r   <= {AW{1'b0}};
        end else begin
            state_r <= state_s;
            adr_r   <= adr_s;
        end
    end

    // Read data register, fetched one cycle ahead of the beat that uses it.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            dat_r <= {DW{1'b0}};
        end else if (state_r != ST_ERR) begin
            dat_r <= mem_r[rd_adr_s];
        end
    end

    // Byte-lane write port; contents survive reset, and no write lands on a reset edge.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i && wr_s) begin
            for (int i = 0; i < SW; i++) begin
                if (wb_sel_i[i]) begin
                    mem_r[adr_r][8*i +: 8] <= wb_dat_i[8*i +: 8];
                end
            end
        end
    end

    assign wb_dat_o = dat_r;
    assign wb_ack_o = ack_s;
    assign wb_err_o = err_s;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_mpsoc_msi_wb_ram_slave.sv
// Randomised self-checking bench for the Wishbone RAM slave against an
// array-based memory model and arithmetic burst-address sequences.
module tb_mpsoc_msi_wb_ram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_o;
    logic        ack, err, rty;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem_m [0:1023];
    logic [31:0] wd_a  [0:1023];
    logic [3:0]  sel_a [0:1023];
    logic        ack_a [0:1023];
    logic [31:0] rd_a  [0:1023];
    logic        ack_pre, ack_post, err_any;

    mpsoc_msi_wb_ram_slave #(.DW(32), .AW(10), .BASE_ADR(32'h0000_0000)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .wb_err_o(err), .wb_rty_o(rty)
    );

    always #5 clk = ~clk;

    function automatic int burst_word(input int s, input int b, input int i);
        int n;
        if (b == 0) return (s + i) % 1024;
        n = 1 << (b + 1);
        return (s - (s % n)) + (((s % n) + i) % n);
    endfunction

    function automatic void model_write(input int w, input logic [3:0] s, input logic [31:0] d);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) mem_m[w][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    task automatic drive(input logic c, input logic s, input logic [31:0] a, input logic w,
                         input logic [3:0] se, input logic [31:0] d, input logic [2:0] ct,
                         input logic [1:0] bt);
        cyc = c; stb = s; adr = a; we = w; sel = se; dat_i = d; cti = ct; bte = bt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 3'b000, 2'b00);
    endtask

    // Single classic access with a release cycle; returns ack/err per cycle.
    task automatic classic(input logic [31:0] a, input logic w, input logic [3:0] se,
                           input logic [31:0] d, output logic [2:0] acks,
                           output logic [2:0] errs, output logic [31:0] rd);
        drive(1'b1, 1'b1, a, w, se, d, 3'b000, 2'b00);
        @(negedge clk); acks[0] = ack; errs[0] = err;
        step();
        @(negedge clk); acks[1] = ack; errs[1] = err; rd = dat_o;
        step();
        idle();
        @(negedge clk); acks[2] = ack; errs[2] = err;
        step();
    endtask

    // Burst driver: records ack and read data per beat into the module arrays.
    task automatic run_burst(input int start, input int b, input int len, input logic w,
                             input logic rand_sel);
        logic [31:0] a;
        a = start * 4 + $urandom_range(0, 3);
        for (int i = 0; i < len; i++) begin
            wd_a[i]  = $urandom;
            sel_a[i] = rand_sel ? 4'($urandom_range(1, 15)) : 4'hf;
        end
        err_any = 1'b0;
        drive(1'b1, 1'b1, a, w, sel_a[0], wd_a[0], (len > 1) ? 3'b010 : 3'b111, 2'(b));
        @(negedge clk); ack_pre = ack; err_any |= err;
        step();
        for (int i = 0; i < len; i++) begin
            drive(1'b1, 1'b1, a, w, sel_a[i], wd_a[i], (i == len - 1) ? 3'b111 : 3'b010, 2'(b));
            @(negedge clk); ack_a[i] = ack; rd_a[i] = dat_o; err_any |= err;
            step();
        end
        drive(1'b1, 1'b1, a, 1'b0, 4'h0, 32'h0, 3'b000, 2'(b));
        @(negedge clk); ack_post = ack; err_any |= err;
        step();
        idle();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, $urandom, 1'b1, 4'hf, $urandom, 3'b010, 2'b00);
        step(); step();
        @(negedge clk);
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", ack); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
        n_chk++; if (rty !== 1'b0) begin n_fail++; $display("FAIL reset_rty got %b exp 0", rty); end
        n_chk++; if (dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat got %h exp 0", dat_o); end
        step();
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (ack !== 1'b0 || dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_release got ack %b dat %h exp 0/0", ack, dat_o); end
        step();
    endtask

    task automatic test_fill();
        int cnt, bad;
        run_burst(0, 0, 1024, 1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            if (ack_a[i] === 1'b1) cnt++;
            model_write(i, sel_a[i], wd_a[i]);
        end
        n_chk++; if (cnt != 1024 || ack_pre !== 1'b0 || ack_post !== 1'b0 || err_any !== 1'b0) begin
            n_fail++; $display("FAIL fill_acks got %0d pre %b post %b err %b exp 1024/0/0/0", cnt, ack_pre, ack_post, err_any); end
        run_burst(0, 0, 1024, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (ack_a[i] !== 1'b1 || rd_a[i] !== mem_m[i]) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL fill_readback got %0d bad words exp 0", bad); end
    endtask

    task automatic test_classic();
        logic [2:0]  acks, errs;
        logic [31:0] rd;
        int          w;
        logic        wr;
        logic [3:0]  s;
        logic [31:0] d;
        classic(32'h10, 1'b1, 4'hf, 32'hDEADBEEF, acks, errs, rd);
        model_write(4, 4'hf, 32'hDEADBEEF);
        n_chk++; if (acks !== 3'b010 || errs !== 3'b000) begin n_fail++; $display("FAIL classic_wr_ack got %b/%b exp 010/000", acks, errs); end
        classic(32'h10, 1'b0, 4'hf, 32'h0, acks, errs, rd);
        n_chk++; if (acks !== 3'b010 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL classic_rd got ack %b dat %h exp 010 deadbeef", acks, rd); end
        classic(32'h10, 1'b1, 4'b0010, 32'h0000AB00, acks, errs, rd);
        model_write(4, 4'b0010, 32'h0000AB00);
        classic(32'h12, 1'b0, 4'hf, 32'h0, acks, errs, rd);
        n_chk++; if (acks !== 3'b010 || rd !== 32'hDEADABEF) begin n_fail++; $display("FAIL byte_lane got ack %b dat %h exp 010 deadabef", acks, rd); end
        for (int k = 0; k < 24; k++) begin
            w  = $urandom_range(0, 1023);
            wr = 1'($urandom_range(0, 1));
            s  = 4'($urandom_range(1, 15));
            d  = $urandom;
            classic(w * 4 + $urandom_range(0, 3), wr, s, d, acks, errs, rd);
            n_chk++; if (acks !== 3'b010 || errs !== 3'b000) begin n_fail++; $display("FAIL rand_classic_ack w %0d got %b/%b exp 010/000", w, acks, errs); end
            if (wr) begin
                model_write(w, s, d);
            end else begin
                n_chk++; if (rd !== mem_m[w]) begin n_fail++; $display("FAIL rand_classic_rd w %0d got %h exp %h", w, rd, mem_m[w]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  p;
        logic [31:0] d;
        d = $urandom;
        drive(1'b1, 1'b1, 32'h0000_0300, 1'b1, 4'hf, d, 3'b000, 2'b00);
        @(negedge clk); p[0] = ack; step();
        @(negedge clk); p[1] = ack; step();
        model_write(192, 4'hf, d);
        drive(1'b1, 1'b1, 32'h0000_0300, 1'b0, 4'hf, 32'h0, 3'b000, 2'b00);
        @(negedge clk); p[2] = ack; step();
        @(negedge clk); p[3] = ack;
        n_chk++; if (dat_o !== d) begin n_fail++; $display("FAIL raw_data got %h exp %h", dat_o, d); end
        step();
        n_chk++; if (p !== 4'b1010) begin n_fail++; $display("FAIL held_stb_acks got %b exp 1010", p); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); p[i] = ack; step();
        end
        idle(); step();
        n_chk++; if (p !== 4'b1010) begin n_fail++; $display("FAIL held_read_acks got %b exp 1010", p); end
    endtask

    task automatic test_err();
        logic [2:0]  acks, errs;
        logic [31:0] rd;
        classic(32'h0000_1000, 1'b1, 4'hf, 32'h1234_5678, acks, errs, rd);
        n_chk++; if (acks !== 3'b000 || errs !== 3'b010) begin n_fail++; $display("FAIL err_wr got ack %b err %b exp 000/010", acks, errs); end
        classic(32'h0000_0000, 1'b0, 4'hf, 32'h0, acks, errs, rd);
        n_chk++; if (acks !== 3'b010 || rd !== mem_m[0]) begin n_fail++; $display("FAIL err_nowrite got %h exp %h", rd, mem_m[0]); end
        classic(32'hFFFF_FFFC, 1'b0, 4'hf, 32'h0, acks, errs, rd);
        n_chk++; if (acks !== 3'b000 || errs !== 3'b010) begin n_fail++; $display("FAIL err_rd got ack %b err %b exp 000/010", acks, errs); end
    endtask

    task automatic test_wrap_burst();
        logic [2:0]  acks, errs;
        logic [31:0] rd;
        for (int i = 0; i < 4; i++) begin
            classic(32'h10 + 4 * i, 1'b1, 4'hf, 32'hA0 + i, acks, errs, rd);
            model_write(4 + i, 4'hf, 32'hA0 + i);
        end
        run_burst(6, 1, 4, 1'b0, 1'b0);
        n_chk++; if (ack_pre !== 1'b0 || ack_post !== 1'b0) begin n_fail++; $display("FAIL wrap4_edges got pre %b post %b exp 0/0", ack_pre, ack_post); end
        n_chk++; if ({ack_a[0], ack_a[1], ack_a[2], ack_a[3]} !== 4'b1111) begin
            n_fail++; $display("FAIL wrap4_acks got %b%b%b%b exp 1111", ack_a[0], ack_a[1], ack_a[2], ack_a[3]); end
        n_chk++; if (rd_a[0] !== 32'hA2 || rd_a[1] !== 32'hA3 || rd_a[2] !== 32'hA0 || rd_a[3] !== 32'hA1) begin
            n_fail++; $display("FAIL wrap4_data got %h %h %h %h exp a2 a3 a0 a1", rd_a[0], rd_a[1], rd_a[2], rd_a[3]); end
    endtask

    task automatic test_bursts();
        int s, b, len, w, bad;
        logic wr;
        for (int k = 0; k < 22; k++) begin
            if (k < 2) begin
                s = 1022; b = 0; len = 4; wr = (k == 0);
            end else begin
                s = $urandom_range(0, 1023); b = $urandom_range(0, 3);
                len = $urandom_range(1, 10); wr = 1'($urandom_range(0, 1));
            end
            run_burst(s, b, len, wr, 1'b1);
            bad = 0;
            for (int i = 0; i < len; i++) begin
                w = burst_word(s, b, i);
                if (ack_a[i] !== 1'b1) bad++;
                if (wr) model_write(w, sel_a[i], wd_a[i]);
                else if (rd_a[i] !== mem_m[w]) bad++;
            end
            n_chk++; if (bad != 0 || ack_pre !== 1'b0 || ack_post !== 1'b0 || err_any !== 1'b0) begin
                n_fail++; $display("FAIL burst s %0d bte %0d len %0d we %b bad %0d pre %b post %b err %b exp 0/0/0/0", s, b, len, wr, bad, ack_pre, ack_post, err_any); end
        end
    endtask

    task automatic test_early_term();
        logic [2:0]  acks, errs;
        logic [31:0] rd, d0, d1;
        logic [2:0]  stop_cti;
        int          base;
        for (int v = 0; v < 2; v++) begin
            base = (v == 0) ? 8 : 16;
            stop_cti = (v == 0) ? 3'b010 : 3'b000;
            d0 = $urandom; d1 = $urandom;
            drive(1'b1, 1'b1, base * 4, 1'b1, 4'hf, d0, 3'b010, 2'b00);
            @(negedge clk);
            n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL early_first v%0d got %b exp 0", v, ack); end
            step();
            @(negedge clk);
            n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL early_beat0 v%0d got %b exp 1", v, ack); end
            step();
            drive(1'b1, 1'b1, base * 4, 1'b1, 4'hf, d1, 3'b010, 2'b00);
            @(negedge clk);
            n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL early_beat1 v%0d got %b exp 1", v, ack); end
            step();
            drive(1'b1, (v != 0), base * 4, 1'b1, 4'hf, $urandom, stop_cti, 2'b00);
            @(negedge clk);
            n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL early_stop v%0d got %b exp 0", v, ack); end
            step();
            idle(); step();
            model_write(base, 4'hf, d0);
            model_write(base + 1, 4'hf, d1);
            for (int i = 0; i < 3; i++) begin
                classic((base + i) * 4, 1'b0, 4'hf, 32'h0, acks, errs, rd);
                n_chk++; if (acks !== 3'b010 || rd !== mem_m[base + i]) begin
                    n_fail++; $display("FAIL early_word v%0d w %0d got %h exp %h", v, base + i, rd, mem_m[base + i]); end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0]  acks, errs;
        logic [31:0] rd, d0;
        d0 = $urandom;
        drive(1'b1, 1'b1, 32'h80, 1'b1, 4'hf, d0, 3'b010, 2'b00);
        step(); step();
        drive(1'b1, 1'b1, 32'h80, 1'b1, 4'hf, ~d0, 3'b010, 2'b00);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        n_chk++; if (ack !== 1'b0 || err !== 1'b0 || dat_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid got ack %b err %b dat %h exp 0/0/0", ack, err, dat_o); end
        step();
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_release got %b exp 0", ack); end
        step();
        model_write(32, 4'hf, d0);
        classic(32'h84, 1'b0, 4'hf, 32'h0, acks, errs, rd);
        n_chk++; if (acks !== 3'b010 || rd !== mem_m[33]) begin n_fail++; $display("FAIL rst_nowrite got ack %b dat %h exp 010 %h", acks, rd, mem_m[33]); end
        classic(32'h80, 1'b0, 4'hf, 32'h0, acks, errs, rd);
        n_chk++; if (acks !== 3'b010 || rd !== d0) begin n_fail++; $display("FAIL rst_keep got ack %b dat %h exp 010 %h", acks, rd, d0); end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_fill();
        test_classic();
        test_back_to_back();
        test_err();
        test_wrap_burst();
        test_bursts();
        test_early_term();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
